// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: runs one EX/MEM load/store against a multi-cycle
// data memory over req/ack, stalling the pipeline until the access completes.
module mem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              err_o
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       access;
    logic       aligned;

    assign access  = memread_i | memwrite_i;
    assign aligned = (addr_i[1:0] == 2'b00);
    assign stall_o = ((state == IDLE) && access) || (state == WAIT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            // err_o is a single-cycle pulse, only raised on entry to DONE
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            state       <= WAIT;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= memwrite_i;
                            mem_addr_o  <= addr_i;
                            mem_wdata_o <= wdata_i;
                            cnt         <= '0;
                        end else begin
                            state <= DONE;
                            err_o <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // ack takes priority over a timeout expiring in the same cycle
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state     <= DONE;
                        if (!mem_we_o) rdata_o <= mem_rdata_i;
                    end else if (cnt == CNT_LAST) begin
                        mem_req_o <= 1'b0;
                        state     <= DONE;
                        err_o     <= 1'b1;
                        if (!mem_we_o) rdata_o <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage controller between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes a load or store from EX/MEM and runs it against a multi-cycle data memory using a req/ack handshake.
- Drives the global pipeline stall while the access is outstanding.
- Presents the captured load data to MEM/WB's read-data input in the cycle the pipeline is released.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data word width in bits.
- TIMEOUT, 64, maximum WAIT cycles without ack before the access is aborted; legal range 1..255.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- memread_i  in  1  load in MEM stage (from EX/MEM).
- memwrite_i  in  1  store in MEM stage (from EX/MEM).
- addr_i  in  ADDR_W  byte address (EX/MEM ALU result).
- wdata_i  in  DATA_W  store data.
- mem_req_o  out  1  request to data memory.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  ADDR_W  request address.
- mem_wdata_o  out  DATA_W  request write data.
- mem_ack_i  in  1  memory completion, one-cycle pulse.
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i.
- rdata_o  out  DATA_W  load data to MEM/WB.
- stall_o  out  1  freeze all pipeline registers and the PC.
- err_o  out  1  one-cycle pulse on misaligned or timed-out access.

Behaviour:
- States: IDLE, WAIT, DONE (registered). A timeout counter of 8 bits is also registered.
- Reset, asynchronous on rst_i low, including mid-access:
  - state = IDLE, counter = 0.
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - rdata_o = 0, err_o = 0.
  - stall_o is combinational, so it reads 0 while in IDLE with no access.
  - Any in-flight memory access is abandoned; an ack arriving after reset is ignored.
- Access detection: access = memread_i | memwrite_i.
  - If both are asserted, the access is a write; rdata_o is not updated.
- stall_o (combinational) = (state==IDLE & access) | (state==WAIT). It is 0 in DONE.
- IDLE:
  - If access and addr_i[1:0]==0:
    - Go to WAIT.
    - Register mem_req_o=1, mem_we_o=memwrite_i, mem_addr_o=addr_i, mem_wdata_o=wdata_i.
    - Counter = 0.
  - If access and addr_i[1:0]!=0 (misaligned):
    - No memory request is issued.
    - Go to DONE with err_o=1 in the DONE cycle.
  - Otherwise stay in IDLE.
- WAIT:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable.
  - On mem_ack_i:
    - mem_req_o = 0; go to DONE.
    - If it is a read, rdata_o = mem_rdata_i.
  - Else, if counter == TIMEOUT-1:
    - mem_req_o = 0; go to DONE with err_o=1.
    - rdata_o = 0 if it is a read.
  - Else counter increments.
  - If ack arrives in the same cycle the timeout expires, the ack wins and err_o = 0.
- DONE:
  - Lasts exactly one cycle with stall_o=0; the pipeline advances on this edge.
  - Always returns to IDLE.
  - err_o is 0 in every state other than DONE.
- rdata_o holds its value at all times except on a read ack, a read timeout, or reset.
- mem_ack_i outside WAIT is ignored.
- Latency:
  - Aligned access acked on the first WAIT cycle gives 2 stall cycles, with DONE in the third cycle.
  - In general, stall cycles = 1 + WAIT cycles.
  - Misaligned access: 1 stall cycle.
- A non-memory instruction in IDLE causes no stall and no request.
- A back-to-back access after DONE is detected in the IDLE cycle that follows; it is not pipelined.

Test Plan:
- Load, addr=0x10, ack on first WAIT cycle with mem_rdata_i=0xDEADBEEF:
  - stall_o=1 for 2 cycles, mem_we_o=0, mem_addr_o=0x10.
  - DONE cycle: stall_o=0, rdata_o=0xDEADBEEF, err_o=0.
- Store, addr=0x20, wdata=0x12345678, ack after 5 WAIT cycles:
  - mem_req_o/mem_we_o=1 with stable address and data for 5 cycles.
  - stall_o=1 for 6 cycles; rdata_o keeps its previous value.
- Load with addr=0x13:
  - No mem_req_o; stall_o=1 for one cycle.
  - DONE: err_o=1, rdata_o unchanged.
- Load, TIMEOUT=4, no ack:
  - After 4 WAIT cycles: mem_req_o drops, DONE with err_o=1 and rdata_o=0.
  - Repeat with ack in the 4th WAIT cycle: err_o=0 and data is captured.
- rst_i low during WAIT:
  - Immediately: mem_req_o=0, stall_o=0, rdata_o=0, state IDLE.
  - An ack pulse after reset release is ignored.
- memread_i=memwrite_i=1, then a load back-to-back after DONE:
  - First access: mem_we_o=1, no rdata update.
  - Second access: IDLE stall, then a normal read completes.
  - A stray mem_ack_i in IDLE has no effect.
